// File: rtl/hog_pkg.sv
// hog_pkg -- shared widths and frame-geometry defaults for the HOG pipeline.
//   BIN_W         width of one histogram bin (16 integer + 4 fractional bits)
//   NBINS         orientation bins per cell histogram
//   CELL_HIST_W   width of one packed cell histogram (bin 0 at LSBs)
//   BLOCK_HIST_W  width of one packed 2x2 block histogram
//   CELLS_X_DEF   default cells per cell-row (640 px / 8)
//   CELLS_Y_DEF   default cell-rows per frame (480 px / 8)
package hog_pkg;

   localparam int BIN_W        = 20;
   localparam int NBINS        = 9;
   localparam int CELL_HIST_W  = NBINS * BIN_W;
   localparam int BLOCK_HIST_W = 4 * CELL_HIST_W;
   localparam int CELLS_X_DEF  = 80;
   localparam int CELLS_Y_DEF  = 60;

endpackage : hog_pkg

// File: rtl/cell_row_buf.sv
// cell_row_buf -- one cell-row of cell histograms.
//   clk      rising-edge clock
//   we       write enable; writes wdata to mem[addr] on the edge
//   addr     shared read/write address (cell column)
//   wdata    cell histogram to store
//   rd_data  combinational read of mem[addr]; returns the contents from
//            before a same-cycle write (read-before-write)
// Contents are intentionally not reset: the controller never emits a block
// built from a row it has not written in the current frame.
// Retargeting to BRAM adds one cycle of read latency; the controller would
// then need a matching pipeline stage on bin/left.
module cell_row_buf #(
   parameter int DEPTH = hog_pkg::CELLS_X_DEF,
   parameter int W     = hog_pkg::CELL_HIST_W,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rd_data
);

   // Index with just enough bits to address DEPTH entries; the controller
   // keeps addr below DEPTH.
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [IW-1:0] idx;

   assign idx     = addr[IW-1:0];
   assign rd_data = mem[idx];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

endmodule : cell_row_buf

// File: rtl/hog_block_buf.sv
// hog_block_buf -- groups a raster stream of 9-bin cell histograms into
// 36-bin 2x2 HOG blocks.
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   i_sof    start of frame, qualified by i_valid on the first cell
//   i_valid  cell histogram valid
//   bin      cell histogram, bin 0 at LSBs
//   o_valid  block valid
//   block    {bottom-right, bottom-left, top-right, top-left} cell histograms
//   o_bx     block column, 0..CELLS_X-2
//   o_by     block row, 0..CELLS_Y-2
//   o_eof    with o_valid on the last block of the frame
//
// Handshake: i_valid and o_valid are single-cycle pulses with no ready in
// either direction. Every i_valid cell is accepted; every o_valid block must
// be taken by the consumer in that cycle. o_valid only rises one cycle after
// an accepted cell, so the output rate never exceeds the input rate.
module hog_block_buf #(
   parameter int BIN_W   = hog_pkg::BIN_W,
   parameter int CELLS_X = hog_pkg::CELLS_X_DEF,
   parameter int CELLS_Y = hog_pkg::CELLS_Y_DEF,
   parameter int X_W     = 10,
   parameter int Y_W     = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_sof,
   input  logic                      i_valid,
   input  logic [BIN_W*9-1:0]        bin,
   output logic                      o_valid,
   output logic [BIN_W*36-1:0]       block,
   output logic [X_W-1:0]            o_bx,
   output logic [Y_W-1:0]            o_by,
   output logic                      o_eof
);

   import hog_pkg::*;

   localparam int CW = NBINS * BIN_W;

   localparam logic [X_W-1:0] X_LAST = X_W'(CELLS_X - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(CELLS_Y - 1);

   logic [X_W-1:0] cx, cx_eff, cx_nxt;
   logic [Y_W-1:0] cy, cy_eff, cy_nxt;
   logic [CW-1:0]  rd;
   logic [CW-1:0]  tl_r;
   logic [CW-1:0]  left_r;
   logic           emit;
   logic           row_end;
   logic           frame_end;

   // A qualified i_sof forces this cell to (0,0) in the same cycle, so the
   // row buffer address and the emit decision already see the restart.
   always_comb begin
      cx_eff    = cx;
      cy_eff    = cy;
      if (i_valid && i_sof) begin
         cx_eff = '0;
         cy_eff = '0;
      end
      row_end   = (cx_eff == X_LAST);
      frame_end = row_end && (cy_eff == Y_LAST);
      emit      = i_valid && (cx_eff != '0) && (cy_eff != '0);

      cx_nxt    = row_end ? '0 : cx_eff + X_W'(1);
      cy_nxt    = cy_eff;
      if (row_end) begin
         cy_nxt = frame_end ? '0 : cy_eff + Y_W'(1);
      end
   end

   cell_row_buf #(
      .DEPTH (CELLS_X),
      .W     (CW),
      .AW    (X_W)
   ) u_row (
      .clk     (clk),
      .we      (i_valid),
      .addr    (cx_eff),
      .wdata   (bin),
      .rd_data (rd)
   );

   // left_r holds the previous cell of this row and tl_r the row-buffer cell
   // above it. Both refresh on column 0 too, so a block never mixes the end
   // of one row with the start of the next.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cx      <= '0;
         cy      <= '0;
         tl_r    <= '0;
         left_r  <= '0;
         o_valid <= 1'b0;
         o_eof   <= 1'b0;
         block   <= '0;
         o_bx    <= '0;
         o_by    <= '0;
      end else begin
         o_valid <= emit;
         o_eof   <= emit && frame_end;
         if (i_valid) begin
            cx     <= cx_nxt;
            cy     <= cy_nxt;
            tl_r   <= rd;
            left_r <= bin;
         end
         if (emit) begin
            block <= {bin, left_r, rd, tl_r};
            o_bx  <= cx_eff - X_W'(1);
            o_by  <= cy_eff - Y_W'(1);
         end
      end
   end

endmodule : hog_block_buf
